// File: rtl/arb_requester_if.sv
// Job handshake plus arbitration bus of one requester; master is the requester,
// slave is whatever drives jobs and grants (local logic plus arbiter).
interface arb_requester_if #(
    parameter int LEN_W = 8
);
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic [1:0]       request;
    logic [1:0]       grant;
    logic             beat_valid;
    logic             beat_last;
    logic             done;
    logic             timeout_err;

    modport master (
        input  job_valid, job_len, grant,
        output job_ready, request, beat_valid, beat_last, done, timeout_err
    );

    modport slave (
        output job_valid, job_len, grant,
        input  job_ready, request, beat_valid, beat_last, done, timeout_err
    );
endinterface

// File: rtl/arb_requester.sv
// Requester-side client of the 2-way fixed-priority arbitration bus: takes a burst
// job, requests bus ownership, issues one beat per granted cycle, then idles a gap.
// Optional grant-wait abort is enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester #(
    parameter int ID      = 0,
    parameter int LEN_W   = 8,
    parameter int GAP_CYC = 1,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    arb_requester_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        GAP
    } state_t;

    localparam logic             OWN      = 1'(ID);
    localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYC - 1);

    state_t           state_reg;
    logic [LEN_W-1:0] rem_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             request_reg;
    logic             job_ready_reg;
    logic             done_reg;
    logic             timeout_reg;

    logic grant_own;
    logic active;
    logic beat;
    logic last_beat;
    logic expire;

    assign grant_own = bus.grant[OWN];
    assign active    = (state_reg == REQ) || (state_reg == XFER);
    // The arbiter's grant lags request by a cycle, so only REQ/XFER may turn a
    // grant into a beat; a stale grant seen in GAP is ignored here.
    assign beat      = active && grant_own && (rem_reg != '0);
    assign last_beat = beat && (rem_reg == LEN_W'(1));

    logic unused_other_grant;
    assign unused_other_grant = bus.grant[~OWN];

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_reg;

    // Counts consecutive ungranted cycles while owning a request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_reg <= '0;
        end else if (active && !grant_own) begin
            wait_reg <= wait_reg + WAIT_W'(1);
        end else begin
            wait_reg <= '0;
        end
    end

    assign expire = active && !grant_own && (wait_reg == WAIT_W'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign expire             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            gap_reg       <= '0;
            request_reg   <= 1'b0;
            job_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    job_ready_reg <= 1'b1;
                    if (bus.job_valid && job_ready_reg) begin
                        if (bus.job_len == '0) begin
                            // Empty job: completes without touching the bus.
                            done_reg <= 1'b1;
                        end else begin
                            rem_reg       <= bus.job_len;
                            request_reg   <= 1'b1;
                            job_ready_reg <= 1'b0;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ, XFER: begin
                    if (expire) begin
                        request_reg <= 1'b0;
                        rem_reg     <= '0;
                        timeout_reg <= 1'b1;
                        gap_reg     <= GAP_INIT;
                        state_reg   <= GAP;
                    end else if (beat) begin
                        rem_reg <= rem_reg - LEN_W'(1);
                        if (last_beat) begin
                            request_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            gap_reg     <= GAP_INIT;
                            state_reg   <= GAP;
                        end else begin
                            state_reg <= XFER;
                        end
                    end
                end
                GAP: begin
                    if (gap_reg == '0) begin
                        job_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        gap_reg <= gap_reg - GAP_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Only the owned request bit can ever be driven; the other stays tied low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            if (gi == ID) begin : g_own
                assign bus.request[gi] = request_reg;
            end else begin : g_other
                assign bus.request[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.job_ready   = job_ready_reg;
    assign bus.beat_valid  = beat;
    assign bus.beat_last   = last_beat;
    assign bus.done        = done_reg;
    assign bus.timeout_err = timeout_reg;
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: one low-priority (ID=1) and one high-priority
// (ID=0) instance, grants driven by hand as a one-cycle-lagging arbiter would.
module tb_arb_requester;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst;

    int tests  = 0;
    int failed = 0;
    int beats1 = 0;
    int dones1 = 0;
    int touts1 = 0;
    int b_snap;
    int d_snap;
    int t_snap;

    arb_requester_if #(.LEN_W(LEN_W)) bus1 ();
    arb_requester_if #(.LEN_W(LEN_W)) bus0 ();

    arb_requester #(.ID(1), .LEN_W(LEN_W), .GAP_CYC(1), .TIMEOUT(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    arb_requester #(.ID(0), .LEN_W(LEN_W), .GAP_CYC(1), .TIMEOUT(16)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus1.beat_valid === 1'b1) beats1++;
        if (bus1.done === 1'b1) dones1++;
        if (bus1.timeout_err === 1'b1) touts1++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus1.job_valid = 1'b0;
        bus1.job_len   = '0;
        bus1.grant     = 2'b00;
        bus0.job_valid = 1'b0;
        bus0.job_len   = '0;
        bus0.grant     = 2'b00;

        // Reset
        cyc();
        cyc();
        #1;
        check("rst_job_ready1", 32'(bus1.job_ready), 32'd0);
        check("rst_job_ready0", 32'(bus0.job_ready), 32'd0);
        check("rst_request1", 32'(bus1.request), 32'd0);
        check("rst_beat_valid1", 32'(bus1.beat_valid), 32'd0);
        check("rst_done1", 32'(bus1.done), 32'd0);
        check("rst_timeout1", 32'(bus1.timeout_err), 32'd0);
        rst = 1'b1;
        cyc();
        #1;
        check("rel_job_ready1", 32'(bus1.job_ready), 32'd1);
        check("rel_job_ready0", 32'(bus0.job_ready), 32'd1);
        check("rel_request1", 32'(bus1.request), 32'd0);

        // Test 1: len=3, grant one cycle after request, stale grant after the burst
        b_snap = beats1;
        d_snap = dones1;
        bus1.job_valid = 1'b1;
        bus1.job_len   = 8'd3;
        #1;
        check("t1_ready_at_accept", 32'(bus1.job_ready), 32'd1);
        cyc();
        bus1.job_valid = 1'b0;
        #1;
        check("t1_req_rise", 32'(bus1.request), 32'h2);
        check("t1_busy_not_ready", 32'(bus1.job_ready), 32'd0);
        check("t1_no_beat_wait", 32'(bus1.beat_valid), 32'd0);
        cyc();
        bus1.grant = 2'b10;
        #1;
        check("t1_beat1", 32'({bus1.beat_valid, bus1.beat_last}), 32'h2);
        cyc();
        #1;
        check("t1_beat2", 32'({bus1.beat_valid, bus1.beat_last}), 32'h2);
        cyc();
        #1;
        check("t1_beat3_last", 32'({bus1.beat_valid, bus1.beat_last}), 32'h3);
        cyc();
        #1;
        check("t1_req_drop", 32'(bus1.request), 32'd0);
        check("t1_stale_grant_no_beat", 32'(bus1.beat_valid), 32'd0);
        check("t1_done", 32'(bus1.done), 32'd1);
        check("t1_gap_not_ready", 32'(bus1.job_ready), 32'd0);
        bus1.grant = 2'b00;
        cyc();
        #1;
        check("t1_ready_after_gap", 32'(bus1.job_ready), 32'd1);
        check("t1_done_one_cycle", 32'(bus1.done), 32'd0);
        check("t1_beat_count", 32'(beats1 - b_snap), 32'd3);
        check("t1_done_count", 32'(dones1 - d_snap), 32'd1);

        // Test 2: len=4, preempted for 2 cycles after beat 2
        b_snap = beats1;
        d_snap = dones1;
        bus1.job_valid = 1'b1;
        bus1.job_len   = 8'd4;
        cyc();
        bus1.job_valid = 1'b0;
        #1;
        check("t2_req_rise", 32'(bus1.request), 32'h2);
        cyc();
        bus1.grant = 2'b10;
        #1;
        check("t2_beat1", 32'({bus1.beat_valid, bus1.beat_last}), 32'h2);
        cyc();
        #1;
        check("t2_beat2", 32'({bus1.beat_valid, bus1.beat_last}), 32'h2);
        cyc();
        bus1.grant = 2'b01;
        #1;
        check("t2_preempt1_no_beat", 32'(bus1.beat_valid), 32'd0);
        check("t2_preempt1_req_held", 32'(bus1.request), 32'h2);
        cyc();
        #1;
        check("t2_preempt2_no_beat", 32'(bus1.beat_valid), 32'd0);
        check("t2_preempt2_req_held", 32'(bus1.request), 32'h2);
        cyc();
        bus1.grant = 2'b10;
        #1;
        check("t2_beat3", 32'({bus1.beat_valid, bus1.beat_last}), 32'h2);
        check("t2_beat3_req_held", 32'(bus1.request), 32'h2);
        cyc();
        #1;
        check("t2_beat4_last", 32'({bus1.beat_valid, bus1.beat_last}), 32'h3);
        cyc();
        bus1.grant = 2'b00;
        #1;
        check("t2_req_drop", 32'(bus1.request), 32'd0);
        check("t2_done", 32'(bus1.done), 32'd1);
        cyc();
        #1;
        check("t2_ready_after_gap", 32'(bus1.job_ready), 32'd1);
        check("t2_beat_count", 32'(beats1 - b_snap), 32'd4);
        check("t2_done_count", 32'(dones1 - d_snap), 32'd1);

        // Test 3: zero-length job
        bus1.job_valid = 1'b1;
        bus1.job_len   = 8'd0;
        cyc();
        bus1.job_valid = 1'b0;
        #1;
        check("t3_no_request", 32'(bus1.request), 32'd0);
        check("t3_done", 32'(bus1.done), 32'd1);
        check("t3_still_ready", 32'(bus1.job_ready), 32'd1);
        cyc();
        #1;
        check("t3_done_one_cycle", 32'(bus1.done), 32'd0);
        check("t3_no_request_later", 32'(bus1.request), 32'd0);

        // Test 4: reset after 2 of 5 beats
        d_snap = dones1;
        t_snap = touts1;
        bus1.job_valid = 1'b1;
        bus1.job_len   = 8'd5;
        cyc();
        bus1.job_valid = 1'b0;
        cyc();
        bus1.grant = 2'b10;
        #1;
        check("t4_beat1", 32'(bus1.beat_valid), 32'd1);
        cyc();
        #1;
        check("t4_beat2", 32'(bus1.beat_valid), 32'd1);
        rst = 1'b0;
        cyc();
        #1;
        check("t4_rst_request", 32'(bus1.request), 32'd0);
        check("t4_rst_no_beat", 32'(bus1.beat_valid), 32'd0);
        check("t4_rst_not_ready", 32'(bus1.job_ready), 32'd0);
        rst        = 1'b1;
        bus1.grant = 2'b00;
        cyc();
        #1;
        check("t4_ready_after_rel", 32'(bus1.job_ready), 32'd1);
        check("t4_no_done", 32'(bus1.done), 32'd0);
        check("t4_no_timeout", 32'(bus1.timeout_err), 32'd0);
        check("t4_done_count", 32'(dones1 - d_snap), 32'd0);
        check("t4_timeout_count", 32'(touts1 - t_snap), 32'd0);

        // Test 5: grant withheld for 16 cycles
        d_snap = dones1;
        t_snap = touts1;
        bus1.job_valid = 1'b1;
        bus1.job_len   = 8'd2;
        cyc();
        bus1.job_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check("t5_wait_request", 32'(bus1.request), 32'h2);
            check("t5_wait_no_timeout", 32'(bus1.timeout_err), 32'd0);
            cyc();
        end
`ifdef ARB_REQ_TIMEOUT_EN
        #1;
        check("t5_to_req_drop", 32'(bus1.request), 32'd0);
        check("t5_to_pulse", 32'(bus1.timeout_err), 32'd1);
        check("t5_to_no_done", 32'(bus1.done), 32'd0);
        cyc();
        #1;
        check("t5_to_pulse_end", 32'(bus1.timeout_err), 32'd0);
        check("t5_to_ready", 32'(bus1.job_ready), 32'd1);
        check("t5_to_count", 32'(touts1 - t_snap), 32'd1);
        check("t5_to_done_count", 32'(dones1 - d_snap), 32'd0);
`else
        #1;
        check("t5_still_request", 32'(bus1.request), 32'h2);
        check("t5_no_timeout", 32'(bus1.timeout_err), 32'd0);
        bus1.grant = 2'b10;
        #1;
        check("t5_beat1", 32'({bus1.beat_valid, bus1.beat_last}), 32'h2);
        cyc();
        #1;
        check("t5_beat2_last", 32'({bus1.beat_valid, bus1.beat_last}), 32'h3);
        cyc();
        bus1.grant = 2'b00;
        #1;
        check("t5_done", 32'(bus1.done), 32'd1);
        check("t5_req_drop", 32'(bus1.request), 32'd0);
        cyc();
        #1;
        check("t5_ready", 32'(bus1.job_ready), 32'd1);
        check("t5_timeout_count", 32'(touts1 - t_snap), 32'd0);
        check("t5_done_count", 32'(dones1 - d_snap), 32'd1);
`endif

        // Test 6: high-priority instance, len=1, grant one cycle after request
        bus0.job_valid = 1'b1;
        bus0.job_len   = 8'd1;
        cyc();
        bus0.job_valid = 1'b0;
        #1;
        check("t6_req0_rise", 32'(bus0.request), 32'h1);
        check("t6_no_beat_wait", 32'(bus0.beat_valid), 32'd0);
        cyc();
        bus0.grant = 2'b01;
        #1;
        check("t6_beat_last", 32'({bus0.beat_valid, bus0.beat_last}), 32'h3);
        cyc();
        bus0.grant = 2'b00;
        #1;
        check("t6_req0_drop", 32'(bus0.request), 32'd0);
        check("t6_done", 32'(bus0.done), 32'd1);
        check("t6_no_timeout", 32'(bus0.timeout_err), 32'd0);
        cyc();
        #1;
        check("t6_ready", 32'(bus0.job_ready), 32'd1);
        check("t6_done_end", 32'(bus0.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
